spi_reg_ctrl: RTL

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI (CPHA=0) slave register file: NREG writable registers plus read-only din at address NREG.
// Define SPI_READBACK_EN to enable read data on miso; otherwise miso is tied low and din is unused.
module spi_reg_ctrl #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4,
   parameter bit CPOL   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              mosi,
   input  logic              ss,
   input  logic [DATA_W-1:0] din,
   output logic              miso,
   output logic [DATA_W-1:0] dout_p,
   output logic [DATA_W-1:0] dout_n,
   output logic              done,
   output logic              err
);
   localparam int               CNT_W     = 4;
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT} state_t;
   state_t r_state, w_next;

   logic [1:0]                  r_sck_s, r_ss_s, r_mosi_s, r_flush;
   logic                        r_sck_d, r_ss_d, r_armed;
   logic                        w_sck, w_ss, w_mosi;
   logic                        w_lead, w_trail, w_ss_fall, w_ss_rise;
   logic                        w_abort, w_cmd_end, w_data_end, w_rd_bad;
   logic [CNT_W-1:0]            r_bitcnt;
   logic [6:0]                  r_cmd, r_addr;
   logic [7:0]                  w_cmd_full;
   logic [DATA_W-2:0]           r_shift;
   logic [DATA_W-1:0]           w_data;
   logic                        r_wr, r_done, r_err;
   logic [NREG-1:0][DATA_W-1:0] r_regs;

   // The ss synchronizer resets to "high", so a frame requires ss to be seen
   // genuinely high (after the chain has flushed) before a falling edge counts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sck_s  <= {2{CPOL}};
         r_ss_s   <= 2'b11;
         r_mosi_s <= 2'b00;
         r_sck_d  <= CPOL;
         r_ss_d   <= 1'b1;
         r_flush  <= 2'b00;
         r_armed  <= 1'b0;
      end else begin
         r_sck_s  <= {r_sck_s[0], sck};
         r_ss_s   <= {r_ss_s[0], ss};
         r_mosi_s <= {r_mosi_s[0], mosi};
         r_sck_d  <= w_sck;
         r_ss_d   <= w_ss;
         r_flush  <= {r_flush[0], 1'b1};
         if (r_flush[1] && w_ss) r_armed <= 1'b1;
      end
   end

   assign w_sck      = r_sck_s[1];
   assign w_ss       = r_ss_s[1];
   assign w_mosi     = r_mosi_s[1];
   assign w_lead     = (w_sck != r_sck_d) && (w_sck != CPOL);
   assign w_trail    = (w_sck != r_sck_d) && (w_sck == CPOL);
   assign w_ss_fall  = r_armed && r_ss_d && !w_ss;
   assign w_ss_rise  = !r_ss_d && w_ss;
   assign w_abort    = w_ss_rise && (r_state == CMD || r_state == DATA);
   assign w_cmd_end  = (r_state == CMD) && w_lead && (r_bitcnt == CMD_LAST);
   assign w_data_end = (r_state == DATA) && w_lead && (r_bitcnt == DATA_LAST) && !w_ss_rise;
   assign w_cmd_full = {r_cmd, w_mosi};
   assign w_data     = {r_shift, w_mosi};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_ss_fall) w_next = CMD;
         CMD:     if (w_ss_rise) w_next = IDLE; else if (w_cmd_end) w_next = DATA;
         DATA:    if (w_ss_rise) w_next = IDLE; else if (w_data_end) w_next = WAIT;
         WAIT:    if (w_ss_rise) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bitcnt <= '0;
         r_cmd    <= '0;
         r_shift  <= '0;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_regs   <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE || r_state == WAIT || w_ss_rise) r_bitcnt <= '0;
         else if (w_lead) r_bitcnt <= (w_cmd_end || w_data_end) ? '0 : r_bitcnt + CNT_W'(1);
         if (r_state == CMD && w_lead)  r_cmd   <= w_cmd_full[6:0];
         if (r_state == DATA && w_lead) r_shift <= w_data[DATA_W-2:0];
         if (w_cmd_end) begin
            r_wr   <= w_cmd_full[7];
            r_addr <= w_cmd_full[6:0];
         end
         // Abort outranks a write completing in the same cycle.
         if (w_abort || w_rd_bad) begin
            r_err <= 1'b1;
         end else if (w_data_end) begin
            r_done <= 1'b1;
            if (r_wr) begin
               if (r_addr < 7'(NREG)) begin
                  for (int i = 0; i < NREG; i++)
                     if (r_addr == 7'(i)) r_regs[i] <= w_data;
                  r_err <= 1'b0;
               end else begin
                  r_err <= 1'b1;
               end
            end
         end
      end
   end

`ifdef SPI_READBACK_EN
   logic [DATA_W-1:0] r_tx, w_rd_word;

   always_comb begin
      w_rd_word = '0;
      if (w_cmd_full[6:0] == 7'(NREG)) w_rd_word = din;
      for (int i = 0; i < NREG; i++)
         if (w_cmd_full[6:0] == 7'(i)) w_rd_word = r_regs[i];
   end

   // MSB is shown on entry to DATA; the trailing edge of the last command bit
   // must not shift, so shifting starts once a data bit has been sampled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                              r_tx <= '0;
      else if (w_cmd_end)                                    r_tx <= w_rd_word;
      else if (r_state == DATA && w_trail && r_bitcnt != '0) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
   end

   assign w_rd_bad = w_cmd_end && !w_cmd_full[7] && (w_cmd_full[6:0] > 7'(NREG));
   assign miso     = (r_state == DATA && !r_wr) ? r_tx[DATA_W-1] : 1'b0;
`else
   logic w_unused;
   assign w_unused = ^{din, r_regs};
   assign w_rd_bad = 1'b0;
   assign miso     = 1'b0;
`endif

   assign dout_p = r_regs[0];
   assign dout_n = r_regs[1];
   assign done   = r_done;
   assign err    = r_err;
endmodule
